alu_datapath: RTL and testbench

ALU_DATAPATH -- requirements
Module: alu_datapath

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_if.sv | 28 ++
 rtl/alu_add4.sv | 18 +
 rtl/alu_datapath.sv | 93 +++++++++
 tb/tb_alu_datapath.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared widths for the ALU datapath slice.
//   DATA_W : operand / bus width
//   NIB_W  : width of one adder slice
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand, control and flag bundle between the controller and alu_datapath.
//   master : controller side (drives operands/controls, reads status)
//   slave  : alu_datapath side
// The tristate data bus is kept as a plain port on alu_datapath so the
// resolved net sits directly on the module boundary.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] areg;
  logic [DATA_W-1:0] breg;
  logic              doSubtract;
  logic              assertBarE;
  logic              assertBarS;
  logic              aIsZero;
  logic              flagCarry;
  logic              flagShift;

  modport master (
    output areg, breg, doSubtract, assertBarE, assertBarS,
    input  aIsZero, flagCarry, flagShift
  );

  modport slave (
    input  areg, breg, doSubtract, assertBarE, assertBarS,
    output aIsZero, flagCarry, flagShift
  );

endinterface : alu_if

// File: rtl/alu_add4.sv
// One nibble slice of the ripple adder.
//   a, b : nibble operands
//   cin  : carry in
//   s    : nibble sum
//   cout : carry out
module alu_add4
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  assign {cout, s} = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(cin);

endmodule : alu_add4

// File: rtl/alu_datapath.sv
// 8-bit add/subtract + shift-right datapath driving a shared tristate bus.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : alu_if.slave (areg, breg, doSubtract, assertBarE,
//                assertBarS in; aIsZero, flagCarry, flagShift out)
//   dbus       : tristate result bus, released when no enable is low
// Build option: define ALU_SHIFT_EN to include the shift path and flagShift;
// without it assertBarS is ignored and flagShift reads 0.
module alu_datapath
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_if.slave              bus,
  output wire  [DATA_W-1:0] dbus
);

  logic [DATA_W-1:0] other;
  logic [DATA_W-1:0] alu_out;
  logic              carry_mid;
  logic              cout;
  logic              flag_carry;
  logic              flag_shift;
  logic              drive_e;
  logic              drive_s;
  logic [DATA_W-1:0] bus_val;

  // Subtract = A + ~B + 1; the +1 enters as the low slice carry-in.
  assign other = bus.breg ^ {DATA_W{bus.doSubtract}};

  alu_add4 u_add_lo (
    .a    (bus.areg[NIB_W-1:0]),
    .b    (other[NIB_W-1:0]),
    .cin  (bus.doSubtract),
    .s    (alu_out[NIB_W-1:0]),
    .cout (carry_mid)
  );

  alu_add4 u_add_hi (
    .a    (bus.areg[DATA_W-1:NIB_W]),
    .b    (other[DATA_W-1:NIB_W]),
    .cin  (carry_mid),
    .s    (alu_out[DATA_W-1:NIB_W]),
    .cout (cout)
  );

  assign drive_e = ~bus.assertBarE;

  // Carry flag capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_carry <= 1'b0;
    end else if (drive_e) begin
      flag_carry <= cout;
    end
  end

`ifdef ALU_SHIFT_EN
  logic [DATA_W-1:0] shifted;

  // Shift-in bit is the flag value held before this edge.
  assign shifted = {flag_shift, bus.areg[DATA_W-1:1]};
  // Adder output wins when both enables are low.
  assign drive_s = ~bus.assertBarS & bus.assertBarE;

  // Shift flag capture; independent of the bus priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_shift <= 1'b0;
    end else if (~bus.assertBarS) begin
      flag_shift <= bus.areg[0];
    end
  end

  always_comb begin
    bus_val = alu_out;
    if (!drive_e) begin
      bus_val = shifted;
    end
  end
`else
  assign drive_s    = 1'b0;
  assign flag_shift = 1'b0;
  assign bus_val    = alu_out;
`endif

  // Single driver onto the bus; value is selected before the enable.
  assign dbus = (drive_e | drive_s) ? bus_val : {DATA_W{1'bz}};

  assign bus.aIsZero   = (bus.areg == '0);
  assign bus.flagCarry = flag_carry;
  assign bus.flagShift = flag_shift;

endmodule : alu_datapath

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath. A weak probe value is put
// on dbus whenever the DUT is expected to release it; reading the probe
// back shows the bus is undriven.
module tb_alu_datapath;
  import alu_pkg::*;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  localparam logic [7:0] PROBE = 8'hA5;

  logic       clk;
  logic       reset;
  logic       probe_en;
  wire  [7:0] dbus;
  int         n_cmp;
  int         n_bad;

  alu_if bus ();

  alu_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbus  (dbus)
  );

  assign dbus = probe_en ? PROBE : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic be, input logic bs, input logic probe);
    bus.areg       = a;
    bus.breg       = b;
    bus.doSubtract = sub;
    bus.assertBarE = be;
    bus.assertBarS = bs;
    probe_en       = probe;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    check("rst_aiszero", 8'(bus.aIsZero), 8'h01);
    check("rst_carry",   8'(bus.flagCarry), 8'h00);
    check("rst_shift",   8'(bus.flagShift), 8'h00);
    check("rst_idle_bus", dbus, PROBE);

    @(negedge clk);
    reset = 1'b0;

    // Add 35+4A
    drive(8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("add_bus", dbus, 8'h7F);
    check("add_aiszero", 8'(bus.aIsZero), 8'h00);
    edge_then_settle();
    check("add_carry", 8'(bus.flagCarry), 8'h00);

    // Add wrap FF+01
    @(negedge clk);
    drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("wrap_bus", dbus, 8'h00);
    check("wrap_aiszero", 8'(bus.aIsZero), 8'h00);
    edge_then_settle();
    check("wrap_carry", 8'(bus.flagCarry), 8'h01);

    // Idle: bus released, flags hold
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("idle_bus", dbus, PROBE);
    edge_then_settle();
    check("idle_carry_hold", 8'(bus.flagCarry), 8'h01);
    check("idle_shift_hold", 8'(bus.flagShift), 8'h00);

    // Subtract with borrow 01-02
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("sub_borrow_bus", dbus, 8'hFF);
    edge_then_settle();
    check("sub_borrow_carry", 8'(bus.flagCarry), 8'h00);

    // Subtract without borrow 10-01
    @(negedge clk);
    drive(8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("sub_bus", dbus, 8'h0F);
    edge_then_settle();
    check("sub_carry", 8'(bus.flagCarry), 8'h01);

    // Shift chain from flagShift=0 (ignored when the shift path is absent)
    @(negedge clk);
    drive(8'h03, 8'h00, 1'b0, 1'b1, 1'b0, !SHIFT_EN);
    #1;
    check("shift1_bus", dbus, SHIFT_EN ? 8'h01 : PROBE);
    edge_then_settle();
    check("shift1_flag", 8'(bus.flagShift), SHIFT_EN ? 8'h01 : 8'h00);
    check("shift1_carry_hold", 8'(bus.flagCarry), 8'h01);
    @(negedge clk);
    drive(8'h02, 8'h00, 1'b0, 1'b1, 1'b0, !SHIFT_EN);
    #1;
    check("shift2_bus", dbus, SHIFT_EN ? 8'h81 : PROBE);
    edge_then_settle();
    check("shift2_flag", 8'(bus.flagShift), 8'h00);

    // Both enables low: adder owns the bus, both flags capture
    @(negedge clk);
    drive(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("both_bus", dbus, 8'h7F);
    edge_then_settle();
    check("both_carry", 8'(bus.flagCarry), 8'h00);
    check("both_shift", 8'(bus.flagShift), SHIFT_EN ? 8'h01 : 8'h00);

    // Set flags, then async reset between edges
    @(negedge clk);
    drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    edge_then_settle();
    check("pre_rst_carry", 8'(bus.flagCarry), 8'h01);
    check("pre_rst_shift", 8'(bus.flagShift), SHIFT_EN ? 8'h01 : 8'h00);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_carry", 8'(bus.flagCarry), 8'h00);
    check("async_rst_shift", 8'(bus.flagShift), 8'h00);
    check("rst_comb_bus", dbus, 8'h00);
    edge_then_settle();
    check("rst_hold_carry", 8'(bus.flagCarry), 8'h00);
    check("rst_hold_shift", 8'(bus.flagShift), 8'h00);

    // Release mid-operation: first capture on the next enabled edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_carry_wait", 8'(bus.flagCarry), 8'h00);
    edge_then_settle();
    check("post_rst_carry", 8'(bus.flagCarry), 8'h01);
    check("post_rst_shift", 8'(bus.flagShift), SHIFT_EN ? 8'h01 : 8'h00);

    @(negedge clk);
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check("zero_aiszero", 8'(bus.aIsZero), 8'h01);
    check("end_idle_bus", dbus, PROBE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_datapath
